// File: rtl/width_16to12.sv
// width_16to12: repacks a 16-bit word stream into 12-bit words, LSB first.
// Optional stream-end handling is enabled by defining WIDTH_16TO12_LAST_EN.
module width_16to12 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_last,
  output logic        din_rdy,
  output logic [11:0] dout,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic        dout_last
);

  typedef enum logic [2:0] {
    P0,
    P1,
    P2,
    P3,
    FLUSH
  } state_t;

`ifdef WIDTH_16TO12_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [11:0] residue;
  logic        last_q;
  logic        last_in;
  logic        out_free;
  logic        acc;
  logic        emit;
  logic        unused_last;

  // din_last only matters when stream-end handling is built in
  assign last_in     = LAST_EN & din_last;
  assign unused_last = din_last;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= P0;
    else     state <= state_nxt;
  end

  // next-state: P0..P2 advance on accepts, P3/FLUSH drain one word
  always_comb begin
    state_nxt = state;
    unique case (state)
      P0:      if (acc) state_nxt = last_in ? FLUSH : P1;
      P1:      if (acc) state_nxt = last_in ? FLUSH : P2;
      P2:      if (acc) state_nxt = P3;
      P3:      if (out_free) state_nxt = P0;
      FLUSH:   if (out_free) state_nxt = P0;
      default: state_nxt = P0;
    endcase
  end

  // handshake decode: input accept and residue emit
  always_comb begin
    out_free = !dout_vld || dout_rdy;
    din_rdy  = 1'b0;
    emit     = 1'b0;
    unique case (state)
      P0, P1, P2: din_rdy = out_free && !rst;
      P3, FLUSH:  emit    = out_free && !rst;
      default: ;
    endcase
    acc = din_vld && din_rdy;
  end

  // output word, residue and stream-end datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      residue   <= '0;
      last_q    <= 1'b0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
    end else if (acc) begin
      unique case (state)
        P0: begin
          dout    <= din[11:0];
          residue <= {8'h00, din[15:12]};
        end
        P1: begin
          dout    <= {din[7:0], residue[3:0]};
          residue <= {4'h0, din[15:8]};
        end
        P2: begin
          dout    <= {din[3:0], residue[7:0]};
          residue <= din[15:4];
          last_q  <= last_in;
        end
        default: ;
      endcase
      dout_vld  <= 1'b1;
      dout_last <= 1'b0;
    end else if (emit) begin
      // residue upper bits are already zero, so it is the padded word
      dout      <= residue;
      dout_vld  <= 1'b1;
      dout_last <= LAST_EN & ((state == FLUSH) | last_q);
      residue   <= '0;
      last_q    <= 1'b0;
    end else if (dout_vld && dout_rdy) begin
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_width_16to12.sv
// tb_width_16to12: directed vectors with a scoreboard queue of expected
// {last, dout} words checked by an independent output monitor.
module tb_width_16to12;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        din_vld;
  logic        din_last;
  logic        din_rdy;
  logic [11:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic        dout_last;

  logic [12:0] exp_q[$];
  int          n_vec;
  int          n_bad;

  width_16to12 dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .din_last  (din_last),
    .din_rdy   (din_rdy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .dout_last (dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] w, input logic l);
    exp_q.push_back({l, w});
  endtask

  task automatic send(input logic [15:0] w, input logic l);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    din      = w;
    din_vld  = 1'b1;
    din_last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (din_rdy) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    din_vld  = 1'b0;
    din_last = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: word %h not accepted", w);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !dout_vld) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words still expected",
               exp_q.size());
    end
  endtask

  // monitor: every output transfer is compared with the queue head
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && dout_vld && dout_rdy) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: got %h last %b want none",
                   dout, dout_last);
        end else begin
          e = exp_q.pop_front();
          if ({dout_last, dout} !== e) begin
            n_bad++;
            $display("FAIL out_word: got %h last %b want %h last %b",
                     dout, dout_last, e[11:0], e[12]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    din_last = 1'b0;
    dout_rdy = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_dout", {4'h0, dout}, 16'h0);
    chk("rst_vld", {15'h0, dout_vld}, 16'h0);
    chk("rst_last", {15'h0, dout_last}, 16'h0);
    chk("rst_rdy", {15'h0, din_rdy}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_rdy", {15'h0, din_rdy}, 16'h1);

    // full group at full rate
    push(12'h210, 1'b0);
    push(12'h543, 1'b0);
    push(12'h876, 1'b0);
    push(12'hBA9, 1'b0);
    send(16'h3210, 1'b0);
    send(16'h7654, 1'b0);
    send(16'hBA98, 1'b0);
    @(negedge clk);
    #1;
    chk("p3_rdy", {15'h0, din_rdy}, 16'h0);
    drain();

    // backpressure while O1 is presented
    push(12'h210, 1'b0);
    push(12'h543, 1'b0);
    push(12'h876, 1'b0);
    push(12'hBA9, 1'b0);
    send(16'h3210, 1'b0);
    send(16'h7654, 1'b0);
    dout_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_dout", {4'h0, dout}, 16'h0543);
      chk("bp_vld", {15'h0, dout_vld}, 16'h1);
      chk("bp_rdy", {15'h0, din_rdy}, 16'h0);
    end
    dout_rdy = 1'b1;
    send(16'hBA98, 1'b0);
    drain();

    // reset in the middle of a group discards the pending word
    dout_rdy = 1'b0;
    send(16'h3210, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_rdy", {15'h0, din_rdy}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_vld", {15'h0, dout_vld}, 16'h0);
    chk("rst_mid_dout", {4'h0, dout}, 16'h0);
    dout_rdy = 1'b1;
    push(12'h654, 1'b0);
    push(12'h987, 1'b0);
    push(12'hCBA, 1'b0);
    push(12'hFED, 1'b0);
    send(16'h7654, 1'b0);
    send(16'hBA98, 1'b0);
    send(16'hFEDC, 1'b0);
    drain();

`ifdef WIDTH_16TO12_LAST_EN
    // last in P0
    push(12'hBCD, 1'b0);
    push(12'h00A, 1'b1);
    send(16'hABCD, 1'b1);
    drain();
    chk("p0_last_rdy", {15'h0, din_rdy}, 16'h1);

    // last in P1
    push(12'h210, 1'b0);
    push(12'h543, 1'b0);
    push(12'h076, 1'b1);
    send(16'h3210, 1'b0);
    send(16'h7654, 1'b1);
    drain();

    // last in P2
    push(12'h210, 1'b0);
    push(12'h543, 1'b0);
    push(12'h876, 1'b0);
    push(12'hBA9, 1'b1);
    send(16'h3210, 1'b0);
    send(16'h7654, 1'b0);
    send(16'hBA98, 1'b1);
    drain();

    // state is back at P0 after the stream end
    push(12'h210, 1'b0);
    send(16'h3210, 1'b0);
    drain();
`else
    // din_last ignored: one word out and the group stays open in P1
    push(12'hBCD, 1'b0);
    send(16'hABCD, 1'b1);
    drain();
    chk("nolast_last", {15'h0, dout_last}, 16'h0);
    chk("nolast_rdy", {15'h0, din_rdy}, 16'h1);
    push(12'h10A, 1'b0);
    push(12'h432, 1'b0);
    push(12'h765, 1'b0);
    send(16'h3210, 1'b0);
    send(16'h7654, 1'b0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/width_16to12.md
WIDTH_16TO12 -- requirements
Module: width_16to12

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port din, input, 16 bits: input word.
REQ-004 SHALL have port din_vld, input, 1 bit: din valid.
REQ-005 SHALL have port din_last, input, 1 bit: marks the final word of a stream; qualified by din_vld && din_rdy.
REQ-006 SHALL have port din_rdy, output, 1 bit: combinational; input accepted when din_vld && din_rdy.
REQ-007 SHALL have port dout, output, 12 bits: registered output word.
REQ-008 SHALL have port dout_vld, output, 1 bit: registered; dout valid.
REQ-009 SHALL have port dout_rdy, input, 1 bit: downstream ready; output transfer occurs when dout_vld && dout_rdy.
REQ-010 SHALL have port dout_last, output, 1 bit: registered; marks the final output word of a stream.

Function
REQ-011 SHALL pack LSB-first: input group W0,W1,W2 maps to O0=W0[11:0], O1={W1[7:0],W0[15:12]}, O2={W2[3:0],W1[15:8]}, O3=W2[15:4].
REQ-012 SHALL implement states P0, P1, P2 (accepting W0, W1, W2), P3 (drain, no input) and FLUSH (emit padded residue).
REQ-013 SHALL hold a 12-bit residue register: 4 bits after P0, 8 bits after P1, 12 bits after P2.
REQ-014 SHALL define out_free = !dout_vld || dout_rdy.
REQ-015 SHALL drive din_rdy = out_free && state in {P0,P1,P2} && !rst.
REQ-016 SHALL load dout one cycle after the accepting edge (latency 1), and SHALL advance P0->P1->P2->P3.
REQ-017 SHALL, in P3 when out_free, load dout=residue[11:0] and return to P0; the P0..P3 sequence SHALL NOT consume input in P3.
REQ-018 SHALL hold dout, dout_vld and dout_last stable while dout_vld && !dout_rdy.
REQ-019 SHALL clear dout_vld when the output is accepted and no new word loads on the same edge.
REQ-020 SHALL, in P0/P1/P2 without an accepted input, hold the state and residue.
REQ-021 SHALL sustain one output per cycle when dout_rdy=1, which gives three input accepts per four output words.

Reset
REQ-022 SHALL, on any rising edge with rst=1, set state=P0, residue=0, dout=0, dout_vld=0, dout_last=0.
REQ-023 SHALL discard any partial group and pending output when rst is asserted mid-group; output SHALL resume at O0 of the next accepted word.
REQ-024 SHALL hold din_rdy=0 while rst=1.

Configuration
REQ-025 SHALL gate stream-end handling with macro WIDTH_16TO12_LAST_EN.
REQ-026 SHALL, with WIDTH_16TO12_LAST_EN defined, handle din_last as follows:
- Last accepted in P0: emit O0, then FLUSH emits {8'h00,residue[3:0]} with dout_last=1.
- Last accepted in P1: emit O1, then FLUSH emits {4'h0,residue[7:0]} with dout_last=1.
- Last accepted in P2: emit O2, then P3 emits O3 with dout_last=1.
- FLUSH and P3 SHALL then return to P0.
REQ-027 SHALL, with WIDTH_16TO12_LAST_EN defined, hold din_rdy=0 in FLUSH.
REQ-028 SHALL, without WIDTH_16TO12_LAST_EN, ignore din_last, never enter FLUSH, and tie dout_last to 0.

Verification
REQ-029 SHALL cover full group: din 16'h3210, 16'h7654, 16'hBA98 on consecutive cycles, dout_rdy=1 -> dout 12'h210, 12'h543, 12'h876, 12'hBA9 on four consecutive cycles, with din_rdy=0 in the P3 cycle.
REQ-030 SHALL cover last in P0 (LAST_EN): single word 16'hABCD with din_last=1 -> dout 12'hBCD (last=0), then 12'h00A (last=1), then state P0.
REQ-031 SHALL cover last in P1 (LAST_EN): 16'h3210, then 16'h7654 with din_last=1 -> dout 12'h210, 12'h543, 12'h076 (last=1).
REQ-032 SHALL cover backpressure: dout_rdy=0 for 5 cycles while O1=12'h543 is valid -> dout held at 12'h543, din_rdy=0, no data lost, sequence completes after dout_rdy=1.
REQ-033 SHALL cover reset mid-group: rst=1 for one cycle after accepting 16'h3210 -> dout_vld=0, dout=0; next input 16'h7654 produces 12'h654 first.
REQ-034 SHALL cover the macro disabled: same stimulus as REQ-030 -> only 12'hBCD is output, dout_last=0, state P1 retained.
